// File: rtl/palette_bank_ram.sv
// Byte-lane palette RAM with a self-clearing sequencer.
// Reads are one-cycle latency and write-first on a same-address hit.
module palette_bank_ram #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 8,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_req_i,
    input  logic                 wr_en_i,
    input  logic [DATA_W/8-1:0]  ben_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [DATA_W-1:0]    wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [DATA_W-1:0]    rd_data_o,
    output logic                 rd_valid_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 wr_ignored_o
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NUM_BE = DATA_W / 8;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                idle;
    logic                wr_ok;
    logic                rd_ok;
    logic [DATA_W-1:0]   rd_merge;

    assign idle  = (state == S_IDLE);
    // A write colliding with an accepted clear request is dropped too.
    assign wr_ok = idle && wr_en_i && !clear_req_i;
    assign rd_ok = idle && rd_en_i;

    always_comb begin
        rd_merge = mem[rd_addr_i];
        if (wr_ok && (wr_addr_i == rd_addr_i)) begin
            for (int k = 0; k < NUM_BE; k++) begin
                if (ben_i[k]) begin
                    rd_merge[8*k +: 8] = wr_data_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == S_CLEAR) begin
                mem[cnt] <= CLEAR_VALUE;
            end else if (wr_ok) begin
                for (int k = 0; k < NUM_BE; k++) begin
                    if (ben_i[k]) begin
                        mem[wr_addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_CLEAR;
            cnt          <= '0;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            rd_data_o    <= '0;
            rd_valid_o   <= 1'b0;
            wr_ignored_o <= 1'b0;
        end else begin
            done_o       <= 1'b0;
            rd_valid_o   <= 1'b0;
            wr_ignored_o <= wr_en_i && !wr_ok;
            unique case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (clear_req_i) begin
                        state  <= S_CLEAR;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end
                default: state <= S_CLEAR;
            endcase
            if (rd_ok) begin
                rd_data_o  <= rd_merge;
                rd_valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_palette_bank_ram.sv
// Scenario bench for palette_bank_ram with a read-result scoreboard.
// Expected read data is queued at issue time and checked on rd_valid_o.
module tb_palette_bank_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic        wr_en;
    logic [1:0]  ben;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        wr_ign;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model [256];
    logic [15:0] last_rd;

    palette_bank_ram dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_req_i  (clear_req),
        .wr_en_i      (wr_en),
        .ben_i        (ben),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .rd_en_i      (rd_en),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .busy_o       (busy),
        .done_o       (done),
        .wr_ignored_o (wr_ign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        clear_req = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        ben       = 2'b00;
        wr_addr   = 8'h00;
        wr_data   = 16'h0000;
        rd_addr   = 8'h00;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        rst = 1'b1;
        quiet();
        repeat (3) begin
            tick();
            tests++;
            if ({busy, done, rd_valid, wr_ign, rd_data} !== {4'b1000, 16'h0}) begin
                fails++;
                $display("FAIL reset_state got %b_%h exp 1000_0000",
                         {busy, done, rd_valid, wr_ign}, rd_data);
            end
        end
        rst = 1'b0;
        for (int c = 0; c <= 256; c++) begin
            if (c > 0) tick();
            tests++;
            if ({busy, done} !== {c < 256, c == 256}) begin
                fails++;
                $display("FAIL clear_timing c=%0d got busy=%b done=%b exp %b %b",
                         c, busy, done, c < 256, c == 256);
            end
        end
        for (int i = 0; i < 256; i++) begin
            rd_en   = 1'b1;
            rd_addr = 8'(i);
            exp_q.push_back(16'h0000);
            tick();
            if (i == 0) begin
                tests++;
                if (done !== 1'b0) begin
                    fails++;
                    $display("FAIL done_once got %b exp 0", done);
                end
            end
            e = exp_q.pop_front();
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                fails++;
                $display("FAIL clear_read a=%0d got v=%b d=%h exp v=1 d=%h",
                         i, rd_valid, rd_data, e);
            end
        end
        rd_en = 1'b0;
        tick();
        tests++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
            fails++;
            $display("FAIL rd_idle got v=%b d=%h exp v=0 d=0000", rd_valid, rd_data);
        end
        clear_model();
        last_rd = 16'h0000;
    endtask

    task automatic test_byte_enable();
        logic [15:0] e;
        wr_en = 1'b1; wr_addr = 8'h12; ben = 2'b11; wr_data = 16'hABCD;
        tick();
        ben = 2'b01; wr_data = 16'h1234;
        tick();
        tests++;
        if (wr_ign !== 1'b0) begin
            fails++;
            $display("FAIL idle_wr_ign got %b exp 0", wr_ign);
        end
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'h12;
        exp_q.push_back(16'hAB34);
        tick();
        e = exp_q.pop_front();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            fails++;
            $display("FAIL byte_en got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, e);
        end
        last_rd = e;
        rd_en = 1'b0;
        tick();
        tests++;
        if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
            fails++;
            $display("FAIL rd_hold got v=%b d=%h exp v=0 d=%h", rd_valid, rd_data, last_rd);
        end
        model[8'h12] = 16'hAB34;
    endtask

    task automatic test_write_first();
        logic [15:0] e;
        wr_en = 1'b1; wr_addr = 8'h05; ben = 2'b11; wr_data = 16'h1111;
        tick();
        ben = 2'b10; wr_data = 16'h2222;
        rd_en = 1'b1; rd_addr = 8'h05;
        exp_q.push_back(16'h2211);
        tick();
        e = exp_q.pop_front();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            fails++;
            $display("FAIL wr_first got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, e);
        end
        wr_en = 1'b0;
        exp_q.push_back(16'h2211);
        tick();
        e = exp_q.pop_front();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            fails++;
            $display("FAIL wr_first_later got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, e);
        end
        last_rd = e;
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_clear_drop();
        logic [15:0] e;
        wr_en = 1'b1; wr_addr = 8'h40; ben = 2'b11; wr_data = 16'h5555;
        tick();
        clear_req = 1'b1; wr_addr = 8'h41; wr_data = 16'h7777;
        tick();
        quiet();
        tests++;
        if (busy !== 1'b1 || wr_ign !== 1'b1) begin
            fails++;
            $display("FAIL req_drop got busy=%b ign=%b exp 1 1", busy, wr_ign);
        end
        for (int c = 1; c <= 256; c++) begin
            tick();
            tests++;
            if ({busy, done} !== {c < 256, c == 256}) begin
                fails++;
                $display("FAIL clr2_timing c=%0d got busy=%b done=%b", c, busy, done);
            end
            if (c == 1 || c == 11 || c == 12) begin
                tests++;
                if (wr_ign !== (c == 11)) begin
                    fails++;
                    $display("FAIL busy_wr_ign c=%0d got %b exp %b", c, wr_ign, c == 11);
                end
            end
            if (c == 10) begin
                wr_en = 1'b1; wr_addr = 8'h40; ben = 2'b11; wr_data = 16'hFFFF;
            end
            if (c == 11) begin
                wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'h40;
            end
            if (c == 12) begin
                rd_en = 1'b0;
                tests++;
                if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
                    fails++;
                    $display("FAIL busy_rd got v=%b d=%h exp v=0 d=%h",
                             rd_valid, rd_data, last_rd);
                end
            end
        end
        rd_en = 1'b1; rd_addr = 8'h40;
        exp_q.push_back(16'h0000);
        tick();
        rd_en = 1'b0;
        e = exp_q.pop_front();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            fails++;
            $display("FAIL post_clear got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, e);
        end
        last_rd = e;
        clear_model();
        tick();
    endtask

    task automatic test_reset_mid_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 1; c <= 100; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({busy, done, rd_valid, wr_ign, rd_data} !== {4'b1000, 16'h0}) begin
            fails++;
            $display("FAIL mid_reset got %b_%h exp 1000_0000",
                     {busy, done, rd_valid, wr_ign}, rd_data);
        end
        for (int c = 1; c <= 260; c++) begin
            tick();
            tests++;
            if ({busy, done} !== {c < 256, c == 256}) begin
                fails++;
                $display("FAIL restart c=%0d got busy=%b done=%b exp %b %b",
                         c, busy, done, c < 256, c == 256);
            end
        end
        last_rd = 16'h0000;
    endtask

    task automatic test_double_req();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 1; c <= 270; c++) begin
            clear_req = (c == 50);
            tick();
            tests++;
            if ({busy, done} !== {c < 256, c == 256}) begin
                fails++;
                $display("FAIL double_req c=%0d got busy=%b done=%b exp %b %b",
                         c, busy, done, c < 256, c == 256);
            end
        end
        clear_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  addrs [24];
        logic [31:0] r;
        logic [15:0] e;
        for (int i = 0; i < 24; i++) begin
            r        = $urandom;
            addrs[i] = r[7:0];
            ben      = r[9:8];
            wr_addr  = r[7:0];
            r        = $urandom;
            wr_data  = r[15:0];
            wr_en    = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (ben[k]) model[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
            end
            tick();
            tests++;
            if (wr_ign !== 1'b0) begin
                fails++;
                $display("FAIL b2b_wr_ign i=%0d got %b exp 0", i, wr_ign);
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rd_en   = 1'b1;
            rd_addr = addrs[i];
            exp_q.push_back(model[addrs[i]]);
            tick();
            e = exp_q.pop_front();
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                fails++;
                $display("FAIL b2b_read a=%h got v=%b d=%h exp v=1 d=%h",
                         addrs[i], rd_valid, rd_data, e);
            end
        end
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_write_first();
        test_clear_drop();
        test_reset_mid_clear();
        test_double_req();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/palette_bank_ram.md
PALETTE_BANK_RAM -- requirements
Module: palette_bank_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning entry width in bits (multiple of 8, 8..64).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter CLEAR_VALUE, default 0 (DATA_W bits), meaning the value written to every entry by the clear sequencer.
REQ-004 The block SHALL derive NUM_BE = DATA_W/8 byte lanes; ben_i bit k SHALL govern data bits [8k+7:8k].
REQ-005 The block SHALL have port clk_i  input  1  the single clock; all logic on posedge.
REQ-006 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port clear_req_i  input  1  single-cycle request to start a full-memory clear.
REQ-008 The block SHALL have port wr_en_i  input  1  write strobe.
REQ-009 The block SHALL have port ben_i  input  NUM_BE  byte enables for the write.
REQ-010 The block SHALL have port wr_addr_i  input  ADDR_W  write address.
REQ-011 The block SHALL have port wr_data_i  input  DATA_W  write data.
REQ-012 The block SHALL have port rd_en_i  input  1  read strobe.
REQ-013 The block SHALL have port rd_addr_i  input  ADDR_W  read address.
REQ-014 The block SHALL have port rd_data_o  output  DATA_W  registered read data.
REQ-015 The block SHALL have port rd_valid_o  output  1  high for one cycle when rd_data_o carries a new read result.
REQ-016 The block SHALL have port busy_o  output  1  high while the clear sequencer owns the memory.
REQ-017 The block SHALL have port done_o  output  1  one-cycle pulse when a clear completes.
REQ-018 The block SHALL have port wr_ignored_o  output  1  one-cycle pulse when a write is dropped.

Function
REQ-019 The block SHALL implement a two-state FSM: CLEAR and IDLE, with a clear counter of ADDR_W bits.
REQ-020 In CLEAR, each cycle with rst_i low SHALL write CLEAR_VALUE (all lanes) to entry counter, then increment counter.
REQ-021 After writing entry DEPTH-1 the FSM SHALL move to IDLE; in that first IDLE cycle busy_o SHALL be 0 and done_o SHALL be 1.
REQ-022 busy_o SHALL be 1 exactly while the FSM is in CLEAR; a clear SHALL take exactly DEPTH cycles.
REQ-023 In IDLE, clear_req_i high SHALL move the FSM to CLEAR with counter 0; busy_o SHALL be 1 from the next cycle.
REQ-024 clear_req_i while in CLEAR SHALL be ignored (no restart, no extra done_o).
REQ-025 In IDLE, wr_en_i high SHALL update only lanes with ben_i set at wr_addr_i; unset lanes SHALL be preserved.
REQ-026 wr_en_i high while busy_o is 1, or in the cycle clear_req_i is accepted, SHALL be dropped; wr_ignored_o SHALL pulse the next cycle.
REQ-027 In IDLE, rd_en_i high in cycle N SHALL give rd_data_o = entry rd_addr_i and rd_valid_o = 1 in cycle N+1 (latency 1).
REQ-028 Same-cycle read and write to the same address in IDLE SHALL return write-first data: enabled lanes from wr_data_i, other lanes from the old entry.
REQ-029 rd_en_i while busy_o is 1 SHALL be dropped: rd_valid_o stays 0 and rd_data_o holds.
REQ-030 rd_en_i low SHALL leave rd_data_o unchanged and rd_valid_o 0.
REQ-031 Address arithmetic SHALL be unsigned ADDR_W bits with no out-of-range access possible.

Reset
REQ-032 While rst_i is 1: FSM = CLEAR, counter = 0, rd_data_o = 0, rd_valid_o = 0, busy_o = 1, done_o = 0, wr_ignored_o = 0.
REQ-033 The memory contents SHALL NOT be modified while rst_i is 1; clearing begins the first cycle rst_i is 0.
REQ-034 rst_i asserted mid-clear SHALL restart the clear from entry 0 after release.

Verification
REQ-035 Reset held 3 cycles, released at cycle 0 -> busy_o = 1 for cycles 0..255, busy_o = 0 and done_o = 1 at cycle 256 only; all 256 reads return 0x0000.
REQ-036 Idle, write addr 0x12 data 0xABCD ben 2'b11, then ben 2'b01 data 0x1234 -> read addr 0x12 returns 0xAB34 one cycle after rd_en_i, rd_valid_o = 1 that cycle.
REQ-037 Entry 0x05 = 0x1111; same cycle write 0x05 data 0x2222 ben 2'b10 and read 0x05 -> rd_data_o = 0x2211 next cycle; later read returns 0x2211.
REQ-038 clear_req_i pulse, write 0x40 data 0xFFFF at clear cycle 10, read at cycle 11 -> wr_ignored_o pulses, rd_valid_o stays 0; after done_o, read 0x40 returns 0x0000.
REQ-039 rst_i asserted at clear cycle 100 for 1 cycle -> busy_o stays 1, done_o pulses exactly 256 cycles after release, not earlier.
REQ-040 clear_req_i pulsed again at clear cycle 50 -> done_o pulses once, at clear cycle 256 of the original clear.
